// File: rtl/ma216_audio_pkg.sv
// Shared constants and helpers for the MA216 audio output path.
package ma216_audio_pkg;

  localparam int         SAMPLE_W    = 16;
  localparam logic [7:0] DAC_SILENCE = 8'h80;
  localparam logic [8:0] GAIN_UNITY  = 9'd256;

  // Offset-binary DAC code to two's complement, left-justified in 16 bits.
  function automatic logic signed [SAMPLE_W-1:0] dac_to_pcm(input logic [7:0] dac);
    return {dac ^ DAC_SILENCE, 8'h00};
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > 17'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -17'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ma216_audio_out_if.sv
// Sample-side bundle between the MA216 DAC latch and the mixer.
interface ma216_audio_out_if;
  import ma216_audio_pkg::*;

  logic [7:0]                 dac_in;
  logic                       mute;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       sample_valid;

  modport master (output dac_in, output mute, input sample, input sample_valid);
  modport slave  (input dac_in, input mute, output sample, output sample_valid);

endinterface

// File: rtl/ma216_dc_block.sv
// DC-blocking high-pass stage with saturation; used only when AUDIO_DCBLOCK_EN is defined.
module ma216_dc_block
  import ma216_audio_pkg::*;
#(
  parameter int DC_SHIFT = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] g,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid
);

  localparam int DACC_W = SAMPLE_W + DC_SHIFT;
  localparam int DIFF_W = SAMPLE_W + 1;

  logic signed [DACC_W-1:0]   dacc_r;
  logic signed [DACC_W-1:0]   dacc_nxt_s;
  logic signed [SAMPLE_W-1:0] dc_s;
  logic signed [DIFF_W-1:0]   diff_s;

  // The estimate subtracted from this sample comes from the pre-update accumulator.
  assign dc_s       = SAMPLE_W'(dacc_r >>> DC_SHIFT);
  assign dacc_nxt_s = dacc_r + DACC_W'(g) - DACC_W'(dc_s);
  assign diff_s     = DIFF_W'(g) - DIFF_W'(dc_s);

  // Accumulator and saturated output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dacc_r       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= in_valid;
      if (in_valid) begin
        dacc_r <= dacc_nxt_s;
        sample <= sat16(diff_s);
      end
    end
  end

endmodule

// File: rtl/ma216_audio_out.sv
// MA216 audio output: tick divider, RC low-pass model, anti-pop gain ramp, gain apply.
// Optional DC blocker stage enabled by defining AUDIO_DCBLOCK_EN.
module ma216_audio_out
  import ma216_audio_pkg::*;
#(
  parameter int DIV      = 64,
  parameter int LP_SHIFT = 2,
  parameter int DC_SHIFT = 10
) (
  input  logic              clk,
  input  logic              reset,
  ma216_audio_out_if.slave  aud
);

  localparam int ACC_W  = SAMPLE_W + LP_SHIFT;
  localparam int PROD_W = 25;

  if (DIV < 1 || DIV > 65535 || LP_SHIFT < 0 || LP_SHIFT > 8 || DC_SHIFT < 0 || DC_SHIFT > 16) begin : g_bad_param
    $error("ma216_audio_out: parameter out of range");
  end

  logic [15:0]                cnt_r;
  logic                       tick_s;
  logic signed [SAMPLE_W-1:0] x_s;
  logic signed [ACC_W-1:0]    acc_r;
  logic signed [ACC_W-1:0]    acc_nxt_s;
  logic signed [SAMPLE_W-1:0] y_r;
  logic [8:0]                 gain_r;
  logic [8:0]                 gain_nxt_s;
  logic                       s1_valid_r;
  logic signed [PROD_W-1:0]   y_ext_s;
  logic signed [PROD_W-1:0]   gain_ext_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [SAMPLE_W-1:0] g_s;
  logic signed [SAMPLE_W-1:0] g_r;
  logic                       g_valid_r;

  assign tick_s = (cnt_r == 16'(DIV - 1));

  // Sample-rate divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 16'd0;
    end else if (tick_s) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  // y converges exactly onto x, so the wider accumulator can never overflow.
  assign x_s       = dac_to_pcm(aud.dac_in);
  assign acc_nxt_s = acc_r + ACC_W'(x_s) - (acc_r >>> LP_SHIFT);

  // Gain steps one LSB per tick, reversing from wherever it is when mute flips.
  always_comb begin
    gain_nxt_s = gain_r;
    if (aud.mute) begin
      if (gain_r != 9'd0) begin
        gain_nxt_s = gain_r - 9'd1;
      end else begin
        gain_nxt_s = 9'd0;
      end
    end else begin
      if (gain_r < GAIN_UNITY) begin
        gain_nxt_s = gain_r + 9'd1;
      end else begin
        gain_nxt_s = GAIN_UNITY;
      end
    end
  end

  // Stage 1: filter and gain update on the edge closing a tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r      <= '0;
      y_r        <= '0;
      gain_r     <= 9'd0;
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= tick_s;
      if (tick_s) begin
        acc_r  <= acc_nxt_s;
        y_r    <= SAMPLE_W'(acc_nxt_s >>> LP_SHIFT);
        gain_r <= gain_nxt_s;
      end
    end
  end

  assign y_ext_s    = PROD_W'(y_r);
  assign gain_ext_s = {16'd0, gain_r};
  assign prod_s     = y_ext_s * gain_ext_s;
  assign g_s        = SAMPLE_W'(prod_s >>> 8);

  // Stage 2: gain apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      g_r       <= '0;
      g_valid_r <= 1'b0;
    end else begin
      g_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        g_r <= g_s;
      end
    end
  end

`ifdef AUDIO_DCBLOCK_EN
  logic signed [SAMPLE_W-1:0] dc_sample_s;
  logic                       dc_valid_s;

  ma216_dc_block #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_block (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (g_valid_r),
    .g            (g_r),
    .sample       (dc_sample_s),
    .sample_valid (dc_valid_s)
  );

  assign aud.sample       = dc_sample_s;
  assign aud.sample_valid = dc_valid_s;
`else
  assign aud.sample       = g_r;
  assign aud.sample_valid = g_valid_r;
`endif

endmodule

// File: tb/tb_ma216_audio_out.sv
// Bench for ma216_audio_out: two instances (DIV=4/LP=2 and DIV=1/LP=0) against an arithmetic reference.
module tb_ma216_audio_out;
  import ma216_audio_pkg::*;

  localparam int DIV_A = 4;
  localparam int LP_A  = 2;
  localparam int DIV_B = 1;
  localparam int LP_B  = 0;
  localparam int DCS   = 10;
`ifdef AUDIO_DCBLOCK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [7:0] dac;
    int         exp_s;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ma216_audio_out_if bus_a ();
  ma216_audio_out_if bus_b ();

  ma216_audio_out #(.DIV(DIV_A), .LP_SHIFT(LP_A), .DC_SHIFT(DCS)) u_a (
    .clk (clk), .reset (reset), .aud (bus_a)
  );
  ma216_audio_out #(.DIV(DIV_B), .LP_SHIFT(LP_B), .DC_SHIFT(DCS)) u_b (
    .clk (clk), .reset (reset), .aud (bus_b)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;
  logic [7:0] dac [2];
  logic       mute [2];
  int         m_div [2];
  int         m_lp [2];
  int         m_cnt [2];
  int         m_gain [2];
  int         m_last [2];
  int         m_ticks [2];
  longint     m_acc [2];
  longint     m_dacc [2];
  int         pend [int];
  bit         live = 1'b0;
  bit         obs_v [2];
  int         obs_s [2];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_acc[i]  = 0;
      m_dacc[i] = 0;
      m_gain[i] = 0;
      m_last[i] = 0;
    end
    pend.delete();
    live = 1'b1;
  endtask

  // One clock of the reference: on tick cycles compute the whole sample and schedule it LAT clocks out.
  task automatic model_clock(input int i);
    longint x, y, g, o, dc;
    if (m_cnt[i] == m_div[i] - 1) begin
      x = (longint'(dac[i]) - 128) * 256;
      m_acc[i] = m_acc[i] + x - (m_acc[i] >>> m_lp[i]);
      y = m_acc[i] >>> m_lp[i];
      if (mute[i]) m_gain[i] = (m_gain[i] > 0) ? m_gain[i] - 1 : 0;
      else         m_gain[i] = (m_gain[i] < 256) ? m_gain[i] + 1 : 256;
      g = (y * m_gain[i]) >>> 8;
`ifdef AUDIO_DCBLOCK_EN
      dc = m_dacc[i] >>> DCS;
      m_dacc[i] = m_dacc[i] + g - dc;
      o = g - dc;
      if (o > 32767) o = 32767;
      else if (o < -32768) o = -32768;
`else
      dc = 0;
      o = g + dc;
`endif
      pend[(cyc + LAT) * 2 + i] = int'(o);
      m_cnt[i] = 0;
      m_ticks[i]++;
    end else begin
      m_cnt[i]++;
    end
  endtask

  task automatic observe();
    int key;
    bit ev;
    obs_v[0] = bus_a.sample_valid;
    obs_s[0] = int'(bus_a.sample);
    obs_v[1] = bus_b.sample_valid;
    obs_s[1] = int'(bus_b.sample);
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        key = cyc * 2 + i;
        ev  = pend.exists(key) != 0;
        if (ev) begin
          m_last[i] = pend[key];
          pend.delete(key);
        end
        chk($sformatf("valid_%0d", i), int'(obs_v[i]), int'(ev));
        chk($sformatf("sample_%0d", i), obs_s[i], m_last[i]);
      end
    end
  endtask

  // Called at a falling edge: check this cycle, drive the next, advance one clock.
  task automatic step(input bit rst);
    observe();
    reset        = rst;
    bus_a.dac_in = dac[0];
    bus_a.mute   = mute[0];
    bus_b.dac_in = dac[1];
    bus_b.mute   = mute[1];
    if (rst) begin
      model_reset();
    end else begin
      model_clock(0);
      model_clock(1);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl [8];
    int   first_a, second_a, nval, k, prev, peak, t0;

    tbl[0] = '{8'h00, -32768};
    tbl[1] = '{8'h01, -32512};
    tbl[2] = '{8'h40, -16384};
    tbl[3] = '{8'h7F, -256};
    tbl[4] = '{8'h80, 0};
    tbl[5] = '{8'h81, 256};
    tbl[6] = '{8'hC0, 16384};
    tbl[7] = '{8'hFF, 32512};

    m_div = '{DIV_A, DIV_B};
    m_lp  = '{LP_A, LP_B};
    dac   = '{8'h80, 8'hFF};
    mute  = '{1'b0, 1'b0};
    m_ticks = '{0, 0};
    bus_a.dac_in = dac[0];
    bus_a.mute   = mute[0];
    bus_b.dac_in = dac[1];
    bus_b.mute   = mute[1];
    @(negedge clk);

    for (int c = 0; c < 3; c++) begin
      step(1'b1);
      if (c > 0) begin
        chk("rst_valid_a", int'(obs_v[0]), 0);
        chk("rst_sample_a", obs_s[0], 0);
        chk("rst_valid_b", int'(obs_v[1]), 0);
      end
    end

    // Release: A idles at silence, B ramps up on full scale.
    first_a = -1; second_a = -1; nval = 0; k = 0; peak = 0;
    for (int c = 0; c < 1100; c++) begin
      step(1'b0);
      if (obs_v[0]) begin
        if (first_a < 0) first_a = c;
        else if (second_a < 0) second_a = c;
      end
      if (c >= 2 && obs_v[1]) nval++;
      if (obs_v[1] && obs_s[1] > peak) peak = obs_s[1];
`ifndef AUDIO_DCBLOCK_EN
      if (obs_v[1]) begin
        k++;
        chk("ramp_b", obs_s[1], (k < 256) ? ((32512 * k) >>> 8) : 32512);
      end
`endif
    end
    chk("first_strobe_a", first_a, DIV_A - 1 + LAT);
    chk("strobe_period_a", second_a - first_a, DIV_A);
    chk("div1_always_valid_b", nval, 1098);

`ifndef AUDIO_DCBLOCK_EN
    for (int t = 0; t < 8; t++) begin
      dac[1] = tbl[t].dac;
      repeat (4) step(1'b0);
      chk($sformatf("table_%02h", tbl[t].dac), obs_s[1], tbl[t].exp_s);
    end

    // Low-pass step response on A at unity gain.
    dac[0] = 8'hFF;
    step(1'b0);
    step(1'b0);
    k = 0; prev = 0;
    for (int c = 0; c < 64 * DIV_A + 8; c++) begin
      step(1'b0);
      if (obs_v[0]) begin
        k++;
        if (k == 1) chk("lp_first", obs_s[0], 8128);
        if (k == 2) chk("lp_second", obs_s[0], 14224);
        chk("lp_monotonic", int'(obs_s[0] >= prev), 1);
        prev = obs_s[0];
      end
    end
    chk("lp_settled", obs_s[0], 32512);

    // Mute ramp on A, reversed after 100 ticks.
    mute[0] = 1'b1;
    step(1'b0);
    step(1'b0);
    k = 0; prev = 32512;
    for (int c = 0; c < 110 * DIV_A; c++) begin
      step(1'b0);
      if (obs_v[0]) begin
        k++;
        if (k <= 100) chk("mute_nonincr", int'(obs_s[0] <= prev), 1);
        prev = obs_s[0];
        if (k == 100) begin
          chk("mute_100", obs_s[0], 19812);
          mute[0] = 1'b0;
        end
        if (k == 101) chk("unmute_101", obs_s[0], 19939);
      end
    end

    mute[1] = 1'b1;
    repeat (262) step(1'b0);
    chk("mute_zero_b", obs_s[1], 0);
    mute[1] = 1'b0;
    repeat (262) step(1'b0);
`else
    chk("dc_step_seen", int'(peak > 16000), 1);
    repeat (33000) step(1'b0);
    chk("dc_decayed_b", obs_s[1], 0);
    dac[1] = 8'h00;
    step(1'b0);
    step(1'b0);
    first_a = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      if (obs_v[1] && first_a == 0) begin
        first_a = 1;
        chk("dc_saturate_neg", obs_s[1], -32768);
      end
    end
    chk("dc_saturate_seen", first_a, 1);
`endif

    // Randomized inputs with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        dac[i] = 8'($urandom);
        if ($urandom_range(0, 31) == 0) mute[i] = ~mute[i];
      end
      step($urandom_range(0, 199) == 0);
    end

    // Reset right after an A tick must swallow that sample.
    t0 = m_ticks[0];
    for (int c = 0; c < 8 && m_ticks[0] == t0; c++) step(1'b0);
    chk("tick_before_reset", int'(m_ticks[0] != t0), 1);
    step(1'b1);
    nval = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      nval += int'(obs_v[0]);
    end
    chk("reset_drops_inflight", nval, 0);
    repeat (4) step(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
